// File: rtl/instr_fetch_unit.sv
// Fetch unit: issues PC to instruction memory over req/ack and buffers words toward decode.
// Optional FETCH_ALIGN_CHECK_EN: misaligned PC pushes a flagged entry and stalls until redirect.
module instr_fetch_unit #(
    parameter int DEPTH = 2,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] pc_addr,
    output logic          inc_pc,
    input  logic          redirect,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          instr_valid,
    output logic [DW-1:0] instr,
    output logic [AW-1:0] instr_pc,
    input  logic          instr_ready,
    output logic          instr_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN
    } state_t;

    state_t state;

    logic [DW-1:0] buf_instr [DEPTH];
    logic [AW-1:0] buf_pc    [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;

    logic          ack_ok;
    logic          push;
    logic          pop;
    logic [DW-1:0] push_instr;
    logic [AW-1:0] push_pc;
    logic          slot_free;
    logic          slot_after;

    assign ack_ok      = (state == REQ) && mem_ack && !redirect;
    assign inc_pc      = ack_ok;
    assign instr_valid = (count != '0);
    assign pop         = instr_valid && instr_ready && !redirect;
    assign count_nxt   = count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    assign slot_free   = count < CW'(DEPTH);
    assign slot_after  = count_nxt < CW'(DEPTH);

    assign instr    = buf_instr[rd_ptr];
    assign instr_pc = buf_pc[rd_ptr];

`ifdef FETCH_ALIGN_CHECK_EN
    logic halt;
    logic mis_push;
    logic buf_err [DEPTH];

    // A misaligned fetch never reaches memory; it becomes a flagged entry instead.
    assign mis_push   = (state == IDLE) && !halt && !redirect
                      && slot_free && (pc_addr[1:0] != 2'b00);
    assign push       = ack_ok || mis_push;
    assign push_instr = mis_push ? '0 : mem_rdata;
    assign push_pc    = mis_push ? pc_addr : mem_addr;
    assign instr_err  = buf_err[rd_ptr];
`else
    assign push       = ack_ok;
    assign push_instr = mem_rdata;
    assign push_pc    = mem_addr;
    assign instr_err  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_instr[i] <= '0;
                buf_pc[i]    <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
                buf_err[i]   <= 1'b0;
`endif
            end
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                buf_instr[wr_ptr] <= push_instr;
                buf_pc[wr_ptr]    <= push_pc;
`ifdef FETCH_ALIGN_CHECK_EN
                buf_err[wr_ptr]   <= mis_push;
`endif
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_addr <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
            halt     <= 1'b0;
`endif
        end else begin
`ifdef FETCH_ALIGN_CHECK_EN
            if (redirect) begin
                halt <= 1'b0;
            end else if (mis_push) begin
                halt <= 1'b1;
            end
`endif
            case (state)
                IDLE: begin
`ifdef FETCH_ALIGN_CHECK_EN
                    if (!redirect && slot_free && !halt && !mis_push) begin
`else
                    if (!redirect && slot_free) begin
`endif
                        state    <= REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= pc_addr;
                    end
                end
                REQ: begin
                    if (redirect) begin
                        // In-flight response must still be absorbed before refetching.
                        if (mem_ack) begin
                            state   <= IDLE;
                            mem_req <= 1'b0;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (mem_ack) begin
                        if (slot_after) begin
                            mem_addr <= pc_addr + AW'(4);
                        end else begin
                            state   <= IDLE;
                            mem_req <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: PC model, memory model, scoreboard of fetched words.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_addr;
    logic        inc_pc;
    logic        redirect;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        instr_err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        err;
    } exp_t;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        inc;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
    } obs_t;

    exp_t exp_q[$];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
    endfunction

    assign mem_rdata = memf(mem_addr);

    instr_fetch_unit #(.DEPTH(2), .AW(32), .DW(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pc_addr(pc_addr),
        .inc_pc(inc_pc),
        .redirect(redirect),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata),
        .instr_valid(instr_valid),
        .instr(instr),
        .instr_pc(instr_pc),
        .instr_ready(instr_ready),
        .instr_err(instr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // One clock: drive at negedge, sample, then advance the PC model after posedge.
    task automatic tick(input logic rdy, input logic ack, input logic redir,
                        input logic [31:0] tgt, output obs_t o);
        @(negedge clk);
        instr_ready = rdy;
        mem_ack     = ack;
        redirect    = redir;
        #1;
        o.req   = mem_req;
        o.addr  = mem_addr;
        o.inc   = inc_pc;
        o.valid = instr_valid;
        o.pc    = instr_pc;
        o.instr = instr;
        o.err   = instr_err;
        @(posedge clk);
        #1;
        if (redir) pc_addr = tgt;
        else if (o.inc) pc_addr = pc_addr + 32'd4;
    endtask

    task automatic apply_reset(input logic [31:0] start);
        rst_n       = 1'b0;
        redirect    = 1'b0;
        mem_ack     = 1'b0;
        instr_ready = 1'b0;
        pc_addr     = start;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n       = 1'b0;
        redirect    = 1'b0;
        mem_ack     = 1'b1;
        instr_ready = 1'b1;
        pc_addr     = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", mem_req); end
        checks++;
        if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", mem_addr); end
        checks++;
        if (inc_pc !== 1'b0) begin errors++; $display("FAIL rst_inc got %b exp 0", inc_pc); end
        checks++;
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", instr_valid); end
        checks++;
        if ({instr, instr_pc, instr_err} !== 65'h0) begin
            errors++;
            $display("FAIL rst_head got instr=%h pc=%h err=%b exp 0", instr, instr_pc, instr_err);
        end
    endtask

    task automatic test_reset_mid_req;
        obs_t o;
        exp_t e;
        apply_reset(32'h8);
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'b0, 1'b0, 32'h0, o);
            checks++;
            if (o.req !== 1'b1 || o.addr !== 32'h8 || o.inc !== 1'b0) begin
                errors++;
                $display("FAIL mrst_req got req=%b addr=%h inc=%b exp 1/8/0", o.req, o.addr, o.inc);
            end
        end
        #2;
        mem_ack = 1'b1;
        rst_n   = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || instr_valid !== 1'b0 || mem_addr !== 32'h0 || inc_pc !== 1'b0) begin
            errors++;
            $display("FAIL mrst_async got req=%b valid=%b addr=%h inc=%b exp 0", mem_req, instr_valid, mem_addr, inc_pc);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 1'b0, 32'h0, o);
            checks++;
            if (o.inc !== 1'b0 || o.valid !== 1'b0) begin
                errors++;
                $display("FAIL mrst_noinc got inc=%b valid=%b exp 0/0", o.inc, o.valid);
            end
        end
        tick(1'b0, 1'b1, 1'b0, 32'h0, o);
        checks++;
        if (o.req !== 1'b1 || o.addr !== 32'h8 || o.inc !== 1'b1) begin
            errors++;
            $display("FAIL mrst_ack got req=%b addr=%h inc=%b exp 1/8/1", o.req, o.addr, o.inc);
        end
        exp_q.push_back('{pc: 32'h8, ins: memf(32'h8), err: 1'b0});
        tick(1'b1, 1'b0, 1'b0, 32'h0, o);
        checks++;
        e = exp_q.pop_front();
        if (o.valid !== 1'b1 || {o.pc, o.instr, o.err} !== e) begin
            errors++;
            $display("FAIL mrst_pop got v=%b pc=%h instr=%h exp pc=%h instr=%h", o.valid, o.pc, o.instr, e.pc, e.ins);
        end
    endtask

    task automatic test_zero_wait;
        obs_t o;
        exp_t e;
        logic [31:0] ea;
        int first_pop;
        int npops;
        apply_reset(32'h0);
        ea        = 32'h0;
        first_pop = -1;
        npops     = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b1, 1'b0, 32'h0, o);
            checks++;
            if (o.req !== 1'b1 || o.addr !== ea || o.inc !== 1'b1) begin
                errors++;
                $display("FAIL zw_req got req=%b addr=%h inc=%b exp 1/%h/1", o.req, o.addr, o.inc, ea);
            end
            exp_q.push_back('{pc: ea, ins: memf(ea), err: 1'b0});
            ea += 32'd4;
            if (o.valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL zw_pop unexpected pc=%h", o.pc);
                end else begin
                    e = exp_q.pop_front();
                    if ({o.pc, o.instr, o.err} !== e) begin
                        errors++;
                        $display("FAIL zw_pop got pc=%h instr=%h err=%b exp pc=%h instr=%h err=%b", o.pc, o.instr, o.err, e.pc, e.ins, e.err);
                    end
                end
                if (first_pop < 0) first_pop = i;
                npops++;
            end
        end
        checks++;
        if (first_pop != 1 || npops != 7) begin
            errors++;
            $display("FAIL zw_rate got first=%0d pops=%0d exp 1/7", first_pop, npops);
        end
    endtask

    task automatic test_backpressure;
        obs_t o;
        exp_t e;
        logic [31:0] ea;
        int ninc;
        int nreq;
        apply_reset(32'h0);
        ea   = 32'h0;
        ninc = 0;
        nreq = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b1, 1'b0, 32'h0, o);
            if (o.req) begin
                checks++;
                if (o.addr !== ea) begin
                    errors++;
                    $display("FAIL bp_addr got %h exp %h", o.addr, ea);
                end
                exp_q.push_back('{pc: ea, ins: memf(ea), err: 1'b0});
                ea += 32'd4;
                nreq++;
            end
            if (o.inc) ninc++;
        end
        checks++;
        if (ninc != 2 || nreq != 2 || o.req !== 1'b0 || o.valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall got inc=%0d req=%0d last_req=%b valid=%b exp 2/2/0/1", ninc, nreq, o.req, o.valid);
        end
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b1, 1'b0, 32'h0, o);
            checks++;
            if (o.req) begin
                if (o.addr !== ea || o.inc !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_resume got addr=%h inc=%b exp %h/1", o.addr, o.inc, ea);
                end
                exp_q.push_back('{pc: ea, ins: memf(ea), err: 1'b0});
                ea += 32'd4;
            end else if (o.inc !== 1'b0) begin
                errors++;
                $display("FAIL bp_resume got inc=%b exp 0", o.inc);
            end
            if (o.valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bp_pop unexpected pc=%h", o.pc);
                end else begin
                    e = exp_q.pop_front();
                    if ({o.pc, o.instr, o.err} !== e) begin
                        errors++;
                        $display("FAIL bp_pop got pc=%h instr=%h exp pc=%h instr=%h", o.pc, o.instr, e.pc, e.ins);
                    end
                end
            end
        end
    endtask

    task automatic test_redirect_drain;
        obs_t o;
        exp_t e;
        logic [31:0] ea;
        apply_reset(32'h10);
        tick(1'b0, 1'b0, 1'b0, 32'h0, o);
        tick(1'b0, 1'b0, 1'b1, 32'h100, o);
        checks++;
        if (o.req !== 1'b1 || o.addr !== 32'h10 || o.inc !== 1'b0) begin
            errors++;
            $display("FAIL dr_redir got req=%b addr=%h inc=%b exp 1/10/0", o.req, o.addr, o.inc);
        end
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b0, 1'b0, 32'h0, o);
            checks++;
            if (o.req !== 1'b1 || o.addr !== 32'h10 || o.inc !== 1'b0 || o.valid !== 1'b0) begin
                errors++;
                $display("FAIL dr_hold got req=%b addr=%h inc=%b v=%b exp 1/10/0/0", o.req, o.addr, o.inc, o.valid);
            end
        end
        tick(1'b1, 1'b1, 1'b0, 32'h0, o);
        checks++;
        if (o.req !== 1'b1 || o.addr !== 32'h10 || o.inc !== 1'b0) begin
            errors++;
            $display("FAIL dr_ack got req=%b addr=%h inc=%b exp 1/10/0", o.req, o.addr, o.inc);
        end
        ea = 32'h100;
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b1, 1'b0, 32'h0, o);
            checks++;
            if (i == 0 && (o.req !== 1'b0 || o.valid !== 1'b0)) begin
                errors++;
                $display("FAIL dr_idle got req=%b valid=%b exp 0/0", o.req, o.valid);
            end
            if (o.req) begin
                if (o.addr !== ea || o.inc !== 1'b1) begin
                    errors++;
                    $display("FAIL dr_refetch got addr=%h inc=%b exp %h/1", o.addr, o.inc, ea);
                end
                exp_q.push_back('{pc: ea, ins: memf(ea), err: 1'b0});
                ea += 32'd4;
            end
            if (o.valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL dr_pop unexpected pc=%h", o.pc);
                end else begin
                    e = exp_q.pop_front();
                    if ({o.pc, o.instr, o.err} !== e) begin
                        errors++;
                        $display("FAIL dr_pop got pc=%h instr=%h exp pc=%h instr=%h", o.pc, o.instr, e.pc, e.ins);
                    end
                end
            end
        end
    endtask

    task automatic test_redirect_with_ack;
        obs_t o;
        exp_t e;
        logic [31:0] ea;
        apply_reset(32'h1C);
        tick(1'b0, 1'b1, 1'b0, 32'h0, o);
        exp_q.push_back('{pc: 32'h1C, ins: memf(32'h1C), err: 1'b0});
        tick(1'b1, 1'b1, 1'b1, 32'h200, o);
        checks++;
        if (o.req !== 1'b1 || o.addr !== 32'h20 || o.inc !== 1'b0 || o.valid !== 1'b1) begin
            errors++;
            $display("FAIL ra_redir got req=%b addr=%h inc=%b v=%b exp 1/20/0/1", o.req, o.addr, o.inc, o.valid);
        end
        exp_q.delete();
        tick(1'b0, 1'b0, 1'b0, 32'h0, o);
        checks++;
        if (o.valid !== 1'b0 || o.req !== 1'b0 || o.inc !== 1'b0) begin
            errors++;
            $display("FAIL ra_flush got v=%b req=%b inc=%b exp 0/0/0", o.valid, o.req, o.inc);
        end
        ea = 32'h200;
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b1, 1'b0, 32'h0, o);
            checks++;
            if (o.req !== 1'b1 || o.addr !== ea || o.inc !== 1'b1) begin
                errors++;
                $display("FAIL ra_refetch got req=%b addr=%h inc=%b exp 1/%h/1", o.req, o.addr, o.inc, ea);
            end
            exp_q.push_back('{pc: ea, ins: memf(ea), err: 1'b0});
            ea += 32'd4;
            if (o.valid) begin
                checks++;
                e = exp_q.pop_front();
                if ({o.pc, o.instr, o.err} !== e) begin
                    errors++;
                    $display("FAIL ra_pop got pc=%h instr=%h exp pc=%h instr=%h", o.pc, o.instr, e.pc, e.ins);
                end
            end
        end
    endtask

`ifdef FETCH_ALIGN_CHECK_EN
    task automatic test_align;
        obs_t o;
        exp_t e;
        logic [31:0] ea;
        apply_reset(32'h6);
        exp_q.push_back('{pc: 32'h6, ins: 32'h0, err: 1'b1});
        tick(1'b1, 1'b1, 1'b0, 32'h0, o);
        checks++;
        e = exp_q.pop_front();
        if (o.req !== 1'b0 || o.inc !== 1'b0 || o.valid !== 1'b1 || {o.pc, o.instr, o.err} !== e) begin
            errors++;
            $display("FAIL al_entry got req=%b inc=%b v=%b pc=%h instr=%h err=%b exp 0/0/1/6/0/1", o.req, o.inc, o.valid, o.pc, o.instr, o.err);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b1, 1'b0, 32'h0, o);
            checks++;
            if (o.req !== 1'b0 || o.inc !== 1'b0 || o.valid !== 1'b0) begin
                errors++;
                $display("FAIL al_stall got req=%b inc=%b v=%b exp 0/0/0", o.req, o.inc, o.valid);
            end
        end
        tick(1'b0, 1'b0, 1'b1, 32'h40, o);
        ea = 32'h40;
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b1, 1'b0, 32'h0, o);
            checks++;
            if (o.req) begin
                if (o.addr !== ea || o.inc !== 1'b1) begin
                    errors++;
                    $display("FAIL al_resume got addr=%h inc=%b exp %h/1", o.addr, o.inc, ea);
                end
                exp_q.push_back('{pc: ea, ins: memf(ea), err: 1'b0});
                ea += 32'd4;
            end else if (o.inc !== 1'b0) begin
                errors++;
                $display("FAIL al_resume got inc=%b exp 0", o.inc);
            end
            if (o.valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL al_pop unexpected pc=%h", o.pc);
                end else begin
                    e = exp_q.pop_front();
                    if ({o.pc, o.instr, o.err} !== e) begin
                        errors++;
                        $display("FAIL al_pop got pc=%h err=%b exp pc=%h err=%b", o.pc, o.err, e.pc, e.err);
                    end
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_reset_mid_req();
        test_zero_wait();
        test_backpressure();
        test_redirect_drain();
        test_redirect_with_ack();
`ifdef FETCH_ALIGN_CHECK_EN
        test_align();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Consumer end of the program-counter interface: takes the current fetch address, issues it to instruction memory over a req/ack handshake, and buffers returned words in a small FIFO toward decode.
- Drives the PC's advance strobe (inc_pc) exactly once per accepted memory request.
- Handles control-flow redirects by flushing the buffer and discarding any in-flight response.

Parameters:
- DEPTH, 2, instruction buffer entries (power of 2, >=2)
- AW, 32, address width
- DW, 32, instruction width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pc_addr  in  AW  current PC value (fetch address)
- inc_pc  out  1  one-cycle pulse: PC may advance (sequential or redirect target)
- redirect  in  1  branch/jump taken this cycle; flush and refetch from the new pc_addr after PC update
- mem_req  out  1  memory request valid
- mem_addr  out  AW  memory request address
- mem_ack  in  1  memory has accepted the request and returns data this cycle
- mem_rdata  in  DW  instruction word, valid with mem_ack
- instr_valid  out  1  head of buffer valid
- instr  out  DW  head instruction
- instr_pc  out  AW  address of head instruction
- instr_ready  in  1  decode consumes head when instr_valid && instr_ready
- instr_err  out  1  head entry flagged misaligned (feature only; 0 otherwise)

Behaviour:
- Reset (rst_n=0, async): state=IDLE, buffer empty, count=0, mem_req=0, mem_addr=0, inc_pc=0, instr_valid=0, instr=0, instr_pc=0, instr_err=0.
- FSM states: IDLE, REQ, DRAIN.
- IDLE -> REQ when buffer has a free slot and redirect=0. mem_addr is latched from pc_addr on entry.
- REQ:
  - mem_req=1; mem_addr is held stable until mem_ack.
  - On mem_ack (no redirect): write {mem_rdata, mem_addr} to the buffer and pulse inc_pc for 1 cycle.
  - Next state: REQ with pc_addr+4 if a slot is still free after this cycle's pop/push, else IDLE.
  - The next request's mem_addr is pc_addr+4 (PC updates on the same edge).
- Single outstanding request; mem_ack outside REQ/DRAIN is ignored.
- Redirect, any state:
  - Buffer is cleared next cycle and instr_valid=0.
  - No instruction is popped that cycle, even if instr_ready=1.
  - Redirect in REQ with mem_ack in the same cycle: data is discarded, no inc_pc; go to IDLE.
  - Redirect in REQ without mem_ack: go to DRAIN. mem_req stays 1 with the old address until mem_ack, then data is discarded, no inc_pc; go to IDLE.
  - Redirect in IDLE: stay IDLE one cycle so the PC settles.
- Buffer:
  - Simultaneous push and pop is allowed when full; count is unchanged.
  - Pop when empty is ignored.
  - Wrap-around pointers, log2(DEPTH) bits.
  - instr, instr_pc and instr_err reflect the head combinationally from the registered buffer.
- Latency: with mem_ack in the same cycle as mem_req, instr_valid rises the cycle after ack. Peak rate is 1 instruction/cycle.
- inc_pc never pulses in DRAIN or on discarded data.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - If pc_addr[1:0]!=0 when a request would be issued, no mem_req is raised.
  - One entry is pushed with instr=0, instr_pc=pc_addr and instr_err=1; inc_pc is not pulsed.
  - Fetch then stalls in IDLE until redirect.
- Undefined:
  - instr_err is tied to 0.
  - Address low bits are passed through unchecked.

Test Plan:
- Reset mid-REQ (mem_req=1, addr 0x8): assert rst_n=0 -> mem_req=0, instr_valid=0, count=0 immediately (async). No inc_pc after release until a new ack.
- Zero-wait memory (mem_ack tied 1), instr_ready=1, PC from 0 -> instr_pc sequence 0x0, 0x4, 0x8, 0xC on consecutive cycles. inc_pc=1 every cycle after first request.
- instr_ready=0, DEPTH=2 -> exactly 2 acks and 2 inc_pc pulses, then mem_req=0. Raising instr_ready resumes with mem_addr=0x8.
- Redirect during REQ at addr 0x10 with ack 3 cycles later (PC redirected to 0x100) -> state DRAIN, ack data discarded, no inc_pc. Next request mem_addr=0x100 and first instr_pc=0x100.
- Redirect and mem_ack in the same cycle at addr 0x20 with buffer holding one entry -> buffer empty next cycle, no push, no inc_pc.
- FETCH_ALIGN_CHECK_EN defined, pc_addr=0x6 -> no mem_req. One entry with instr_err=1, instr_pc=0x6, no inc_pc. Redirect to 0x40 resumes normal fetch.
